// File: rtl/m_data_mem_pkg.sv
//------------------------------------------------------------------------------
// m_data_mem_pkg : access-type encodings and size decode for the M-stage data memory
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package m_data_mem_pkg;

    // Access types, shared with the decoder
    localparam logic [2:0] c_DM_W  = 3'd0;
    localparam logic [2:0] c_DM_H  = 3'd1;
    localparam logic [2:0] c_DM_HU = 3'd2;
    localparam logic [2:0] c_DM_B  = 3'd3;
    localparam logic [2:0] c_DM_BU = 3'd4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } dm_size_e;

    // Signed and unsigned variants share a size; unused encodings act as words
    function automatic dm_size_e dm_size(input logic [2:0] op);
        case (op)
            c_DM_H, c_DM_HU: return SZ_HALF;
            c_DM_B, c_DM_BU: return SZ_BYTE;
            default:         return SZ_WORD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_data_mem_ext.sv
//------------------------------------------------------------------------------
// dm_ext : lane select and sign/zero extension of a loaded word
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dm_ext
    import m_data_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  op_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word_i[8*lane_i +: 8];
        w_half = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (op_i)
            c_DM_B:  data_o = {{24{w_byte[7]}}, w_byte};
            c_DM_BU: data_o = {24'h0, w_byte};
            c_DM_H:  data_o = {{16{w_half[15]}}, w_half};
            c_DM_HU: data_o = {16'h0, w_half};
            default: data_o = word_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/m_data_mem.sv
//------------------------------------------------------------------------------
// m_data_mem : word RAM with byte/half/word stores, extended loads, align/range flags
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module m_data_mem
    import m_data_mem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter bit          TRACE      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        exc_align_o,
    output logic        exc_range_o,
    output logic        trace_valid_o,
    output logic [31:0] trace_pc_o,
    output logic [31:0] trace_addr_o,
    output logic [31:0] trace_data_o
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem_q [c_DEPTH];
    logic [31:0]           word_d;
    logic [29:0]           w_word_off;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_old_word;
    logic [31:0]           w_ext;
    logic [31:0]           w_wrep;
    logic [3:0]            w_be;
    logic                  w_commit;
    dm_size_e              w_size;

    // Offset taken in word units so an address below BASE_ADDR wraps high and trips the range check
    assign w_word_off = addr_i[31:2] - BASE_ADDR[31:2];
    assign w_idx      = w_word_off[DEPTH_LOG2-1:0];
    assign w_old_word = mem_q[w_idx];
    assign w_size     = dm_size(mem_op_i);

    always_comb begin
        exc_range_o = mem_en_i && (w_word_off[29:DEPTH_LOG2] != '0);
        case (w_size)
            SZ_HALF: exc_align_o = mem_en_i && addr_i[0];
            SZ_BYTE: exc_align_o = 1'b0;
            default: exc_align_o = mem_en_i && (addr_i[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        case (w_size)
            SZ_HALF: begin
                w_be   = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{wdata_i[15:0]}};
            end
            SZ_BYTE: begin
                w_be   = 4'b0001 << addr_i[1:0];
                w_wrep = {4{wdata_i[7:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wrep = wdata_i;
            end
        endcase
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        assign word_d[8*l +: 8] = w_be[l] ? w_wrep[8*l +: 8] : w_old_word[8*l +: 8];
    end

    assign w_commit = mem_en_i && mem_we_i && !exc_align_o && !exc_range_o && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_commit) begin
            mem_q[w_idx] <= word_d;
        end
    end

    dm_ext u_ext (
        .word_i (w_old_word),
        .lane_i (addr_i[1:0]),
        .op_i   (mem_op_i),
        .data_o (w_ext)
    );

    assign rdata_o = (!mem_en_i || mem_we_i || exc_align_o || exc_range_o) ? 32'h0 : w_ext;

    if (TRACE) begin : g_trace
        assign trace_valid_o = w_commit;
        assign trace_pc_o    = pc_i;
        assign trace_addr_o  = {addr_i[31:2], 2'b00};
        assign trace_data_o  = word_d;
    end else begin : g_no_trace
        assign trace_valid_o = 1'b0;
        assign trace_pc_o    = 32'h0;
        assign trace_addr_o  = 32'h0;
        assign trace_data_o  = 32'h0;
    end

endmodule

`default_nettype wire
